// File: rtl/conta_prog_nb.sv
`default_nettype none
// ============================================================================
//  Module      : conta_prog_nb
//  Description : Programmable up/down counter with enable prescaler, sync
//                clear/load, wrap/saturate/one-shot modes, registered tc/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module conta_prog_nb #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               ena,
  input  logic               up,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   cuenta,
  output logic               tc,
  output logic               done
);

  localparam logic [WIDTH-1:0]   C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] C_P_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_cuenta, w_cuenta_nxt, w_step_val, w_term;
  logic [PRESC_W-1:0] r_pc, w_pc_nxt;
  logic               r_tc, w_tc_nxt, w_step, w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_cuenta <= '0;
      r_pc     <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cuenta <= w_cuenta_nxt;
      r_pc     <= w_pc_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_wrap = (mode == 2'b00) || (mode == 2'b11);
    w_term = up ? limit : '0;
    // pc above a freshly lowered presc still counts as a match
    w_step = ena && (r_state == ST_RUN) && (r_pc >= presc);

    if (up) begin
      if (r_cuenta >= limit) w_step_val = w_wrap ? '0 : limit;
      else                   w_step_val = r_cuenta + C_ONE;
    end else begin
      if (r_cuenta == '0)    w_step_val = w_wrap ? limit : '0;
      else                   w_step_val = r_cuenta - C_ONE;
    end

    w_state_nxt  = r_state;
    w_cuenta_nxt = r_cuenta;
    w_pc_nxt     = r_pc;
    w_tc_nxt     = 1'b0;

    if (clr) begin
      w_state_nxt  = ST_RUN;
      w_cuenta_nxt = '0;
      w_pc_nxt     = '0;
    end else if (load) begin
      w_state_nxt  = ST_RUN;
      w_cuenta_nxt = load_val;
      w_pc_nxt     = '0;
    end else if (ena && (r_state == ST_RUN)) begin
      if (w_step) begin
        w_pc_nxt     = '0;
        w_cuenta_nxt = w_step_val;
        // saturate holding at the terminal value does not re-pulse
        w_tc_nxt     = (w_step_val == w_term) &&
                       !((mode == 2'b01) && (w_step_val == r_cuenta));
        if ((mode == 2'b10) && (w_step_val == w_term)) w_state_nxt = ST_DONE;
      end else begin
        w_pc_nxt = r_pc + C_P_ONE;
      end
    end
  end

  assign cuenta = r_cuenta;
  assign tc     = r_tc;
  assign done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conta_prog_nb.sv
`default_nettype none
// Scoreboarded random/directed bench for conta_prog_nb against a behavioural
// reference model computed from the counting rules.
module tb_conta_prog_nb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0, load = 1'b0, ena = 1'b0, up = 1'b1;
  logic [7:0] load_val = '0, limit = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] presc = '0;
  logic [7:0] cuenta;
  logic       tc, done;

  conta_prog_nb #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .ena(ena), .up(up), .mode(mode), .limit(limit), .presc(presc),
    .cuenta(cuenta), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit tc;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  int m_cnt = 0, m_pc = 0;
  bit m_tc = 0, m_done = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: one clock edge with the current input values.
  task automatic model_edge();
    int lim, nv, t;
    bit wrapm;
    lim   = int'(limit);
    wrapm = (mode == 2'b00) || (mode == 2'b11);
    m_tc  = 0;
    if (clr) begin
      m_cnt = 0; m_pc = 0; m_done = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_pc = 0; m_done = 0;
    end else if (ena && !m_done) begin
      if (m_pc >= int'(presc)) begin
        m_pc = 0;
        t = up ? lim : 0;
        if (up) nv = (m_cnt >= lim) ? (wrapm ? 0 : lim) : m_cnt + 1;
        else    nv = (m_cnt == 0)   ? (wrapm ? lim : 0) : m_cnt - 1;
        m_tc = (nv == t) && !(mode == 2'b01 && nv == m_cnt);
        if (mode == 2'b10 && nv == t) m_done = 1;
        m_cnt = nv;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_edge();
    e.cnt = m_cnt; e.tc = m_tc; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit en,
                       input bit u, input int md, input int lim, input int pr);
    clr = c; load = l; load_val = 8'(lv); ena = en; up = u;
    mode = 2'(md); limit = 8'(lim); presc = 4'(pr);
    cycle();
  endtask

  // Monitor: the DUT presents a new state after every edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cuenta", int'(cuenta), e.cnt);
      check("tc", int'(tc), int'(e.tc));
      check("done", int'(done), int'(e.done));
    end
  end

  initial begin
    int exp2[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    repeat (2) @(posedge clk);
    #2;
    check("reset_cuenta", int'(cuenta), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    // wrap up to 9
    drive(1, 0, 0, 0, 1, 0, 9, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 1, 0, 9, 0);
      check("wrap9_cuenta", int'(cuenta), exp2[i]);
      check("wrap9_tc", int'(tc), (exp2[i] == 9) ? 1 : 0);
    end

    // prescaler with ena gap
    drive(1, 0, 0, 0, 1, 0, 9, 3);
    drive(0, 0, 0, 1, 1, 0, 9, 3);
    drive(0, 0, 0, 0, 1, 0, 9, 3);
    drive(0, 0, 0, 1, 1, 0, 9, 3);
    drive(0, 0, 0, 1, 1, 0, 9, 3);
    drive(0, 0, 0, 1, 1, 0, 9, 3);
    check("presc_step", int'(cuenta), 1);

    // saturate down from 2
    drive(0, 1, 2, 0, 0, 1, 9, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 1, 9, 0);

    // one-shot to 3, frozen, reload resumes
    drive(1, 0, 0, 0, 1, 2, 3, 0);
    repeat (5) drive(0, 0, 0, 1, 1, 2, 3, 0);
    check("oneshot_done", int'(done), 1);
    drive(0, 0, 0, 1, 1, 0, 3, 0);
    drive(0, 1, 1, 0, 1, 2, 3, 0);
    repeat (3) drive(0, 0, 0, 1, 1, 2, 3, 0);

    // clr beats load; load above limit wraps to 0
    drive(1, 1, 77, 1, 1, 0, 50, 0);
    check("clr_over_load", int'(cuenta), 0);
    drive(0, 1, 200, 0, 1, 0, 50, 0);
    drive(0, 0, 0, 1, 1, 0, 50, 0);
    check("over_limit_wrap", int'(cuenta), 0);

    // limit 0 wrap pulses every step, both directions
    repeat (3) drive(0, 0, 0, 1, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 3, 0, 0);

    // async reset mid-count: cuenta=5, pc=2
    drive(0, 1, 5, 0, 1, 0, 20, 3);
    repeat (2) drive(0, 0, 0, 1, 1, 0, 20, 3);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_cuenta", int'(cuenta), 0);
    check("async_rst_tc", int'(tc), 0);
    check("async_rst_done", int'(done), 0);
    m_cnt = 0; m_pc = 0; m_tc = 0; m_done = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      clr  = ($urandom_range(0, 99) < 2);
      load = ($urandom_range(0, 99) < 3);
      load_val = 8'($urandom_range(0, 255));
      ena  = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 5) up = ~up;
      if ($urandom_range(0, 99) < 4) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4)
        limit = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 5) presc = 4'($urandom_range(0, 3));
      cycle();
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
